shot_ctl: RTL and testbench
===========================

// Module: shot_ctl
// PURPOSE
//  Shot sequencer between the player inputs (light gun, mouse) and the draw/duck-control pipeline.
//  Gun shot, Zapper-style: one all-black frame, then one frame with a white box at the duck position,
//  while the photodetector is sampled; the result is a duck_hit pulse.
//  Mouse shot: hit is decided directly by a bounding-box test; no flash frames.
//  Also tracks ammo per duck and drives the flash control inputs of the draw stages.
// PARAMETERS
//  BLACK_FRAMES     1   frames of all-black screen before target frame
//  TARGET_FRAMES    1   frames of white target box; photodetector sampled throughout
//  COOLDOWN_FRAMES  10  frames after a shot before the next trigger is accepted
//  SHOTS_PER_DUCK   3   ammo reloaded on each new duck
//  DUCK_W / DUCK_H  64  duck hit-box size in pixels (mouse test, white box size)
// PORTS
//  clk              in   1   65 MHz pixel clock
//  rst              in   1   synchronous, active-high reset
//  new_frame        in   1   1-cycle pulse at frame start (from vga_timing)
//  gun_trigger      in   1   async, active-high
//  gun_photodetector in  1   async, active-high = light seen
//  mouse_left       in   1   left button, already in clk domain
//  mouse_x, mouse_y in   10  cursor position
//  duck_x, duck_y   in   10  duck top-left corner
//  duck_show        in   1   duck on screen
//  flash_black      out  1   draw stages output black
//  flash_target     out  1   draw stages output black + white DUCK_WxDUCK_H box at duck_x/duck_y
//  duck_hit         out  1   1-cycle pulse: shot hit the duck
//  shot_miss        out  1   1-cycle pulse: shot resolved as miss
//  shots_left       out  2   remaining ammo for current duck
//  busy             out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; flash_black=flash_target=duck_hit=shot_miss=busy=0; shots_left=SHOTS_PER_DUCK.
//  Async inputs pass through 2-FF synchronisers (2-cycle latency); trigger uses rising edge only.
//  Reload: rising edge of duck_show -> shots_left=SHOTS_PER_DUCK next cycle, even if busy.
//  Shot accepted in IDLE only, when duck_show=1 and shots_left>0; otherwise the edge is dropped.
//   Accept decrements shots_left in that cycle. Gun edge wins if gun and mouse edge coincide.
//  FSM (all frame counts advance on new_frame; outputs registered, change the cycle after the edge):
//   IDLE    -gun edge-> ARM; -mouse edge-> MCHECK
//   ARM     -new_frame-> BLACK (flash_black=1), cnt=BLACK_FRAMES
//   BLACK   photodetector=1 at any cycle sets bad flag (ambient light); -cnt done at new_frame-> TARGET
//   TARGET  flash_target=1; photodetector=1 sets seen flag; -cnt done at new_frame-> RESULT
//   MCHECK  1 cycle: hit = duck_x<=mouse_x<duck_x+DUCK_W && duck_y<=mouse_y<duck_y+DUCK_H (11-bit sums,
//           no wrap) -> RESULT
//   RESULT  1 cycle: duck_hit = seen&&!bad (gun) or box test (mouse); else shot_miss -> COOLDOWN
//   COOLDOWN cnt=COOLDOWN_FRAMES frames, then IDLE only once trigger and mouse_left are both low
//  duck_show falling while in ARM/BLACK/TARGET: finish flash sequence, RESULT forced miss.
//  duck_hit and shot_miss are never both high; exactly one per accepted shot.
//  Gun shot latency: trigger edge to result = wait to next frame + BLACK_FRAMES+TARGET_FRAMES frames + 1 cycle.
//  shots_left saturates at 0; never wraps.
//  Reset mid-flash: flash outputs 0 on the cycle after rst is sampled high; no result pulse.
// STRUCTURE
//  dh_pkg: shot_state_t enum, DUCK_W/DUCK_H, coordinate width constant (10).
//  Sub-module sync_edge (2-FF synchroniser + rising-edge detector), instanced for trigger and
//  photodetector (photodetector uses level output only).
//  Main FSM, frame counter and flags live in shot_ctl.
// TESTING
//  1 duck_show=1, gun edge, photodetector high only in TARGET frame -> flash_black 1 frame, flash_target 1 frame,
//    duck_hit 1 cycle, shots_left 3->2
//  2 Same, photodetector high in BLACK too -> shot_miss, no duck_hit
//  3 Mouse click at (duck_x+63,duck_y) -> duck_hit; click at (duck_x+64,duck_y) -> shot_miss;
//    duck_x=1000 tests no wrap
//  4 Three misses, fourth trigger -> ignored, shots_left=0, busy=0; duck_show 0->1 -> shots_left=3
//  5 Trigger held high through cooldown -> stays in COOLDOWN until released; second edge inside cooldown ignored
//  6 rst asserted during TARGET -> next cycle flash_target=0, IDLE, no pulses; duck_show drop in BLACK -> shot_miss

Source files
------------

// File: rtl/dh_pkg.sv
// Shared types and geometry for the shot sequencer: FSM states, coordinate width,
// duck hit-box size and the no-wrap span test used by the mouse hit check.
package dh_pkg;
  localparam int COORD_W = 10;
  localparam int DUCK_W  = 64;
  localparam int DUCK_H  = 64;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_BLACK,
    S_TARGET,
    S_MCHECK,
    S_RESULT,
    S_COOLDOWN
  } shot_state_t;

  // lo <= p < lo+w, evaluated one bit wider so a box near the right/bottom edge never wraps
  function automatic logic in_span(coord_t lo, coord_t p, int unsigned w);
    logic [COORD_W:0] lo_e, p_e, hi_e;
    lo_e = {1'b0, lo};
    p_e  = {1'b0, p};
    hi_e = lo_e + (COORD_W+1)'(w);
    return (p_e >= lo_e) && (p_e < hi_e);
  endfunction
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a rising-edge strobe
// derived from the synchronised level.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);
  // [1:0] metastability chain, [2] previous synchronised level
  logic [2:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[1:0], d};
  end

  assign level = sync_pipe[1];
  assign rise  = sync_pipe[1] & ~sync_pipe[2];
endmodule

// File: rtl/shot_ctl.sv
// Shot sequencer: gun shots run a black frame then a white-target frame while the
// photodetector is watched; mouse shots use a direct box test. Tracks ammo per duck.
module shot_ctl
  import dh_pkg::*;
#(
  parameter int BLACK_FRAMES    = 1,
  parameter int TARGET_FRAMES   = 1,
  parameter int COOLDOWN_FRAMES = 10,
  parameter int SHOTS_PER_DUCK  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         new_frame,
  input  logic         gun_trigger,
  input  logic         gun_photodetector,
  input  logic         mouse_left,
  input  logic [9:0]   mouse_x,
  input  logic [9:0]   mouse_y,
  input  logic [9:0]   duck_x,
  input  logic [9:0]   duck_y,
  input  logic         duck_show,
  output logic         flash_black,
  output logic         flash_target,
  output logic         duck_hit,
  output logic         shot_miss,
  output logic [1:0]   shots_left,
  output logic         busy
);
  localparam int         CNT_W = 8;
  localparam logic [1:0] AMMO  = 2'(SHOTS_PER_DUCK);

  shot_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             bad, bad_nx, seen, seen_nx, dropped, dropped_nx, hit_nx;
  logic [1:0]       shots_nx;
  logic             duck_show_q, mouse_q;
  logic [1:0]       sync_level, sync_rise;
  logic             trig_rise, trig_level, pd_level, unused_pd_rise;
  logic             mouse_rise, show_rise, show_fall, in_flash;

  // lane 0: trigger, lane 1: photodetector
  sync_edge u_sync [1:0] (
    .clk   (clk),
    .rst   (rst),
    .d     ({gun_photodetector, gun_trigger}),
    .level (sync_level),
    .rise  (sync_rise)
  );

  assign trig_level     = sync_level[0];
  assign trig_rise      = sync_rise[0];
  assign pd_level       = sync_level[1];
  assign unused_pd_rise = sync_rise[1];

  assign mouse_rise = mouse_left & ~mouse_q;
  assign show_rise  = duck_show & ~duck_show_q;
  assign show_fall  = ~duck_show & duck_show_q;
  assign in_flash   = (state == S_ARM) || (state == S_BLACK) || (state == S_TARGET);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bad_nx     = bad;
    seen_nx    = seen;
    dropped_nx = dropped | (show_fall & in_flash);
    hit_nx     = 1'b0;
    shots_nx   = shots_left;

    case (state)
      S_IDLE: begin
        if ((trig_rise || mouse_rise) && duck_show && (shots_left != 2'd0)) begin
          state_nx   = trig_rise ? S_ARM : S_MCHECK;
          bad_nx     = 1'b0;
          seen_nx    = 1'b0;
          dropped_nx = 1'b0;
          shots_nx   = shots_left - 2'd1;
        end
      end
      S_ARM: begin
        if (new_frame) begin
          state_nx = S_BLACK;
          cnt_nx   = CNT_W'(BLACK_FRAMES);
        end
      end
      S_BLACK: begin
        // light during the black frame means the gun sees ambient light, not the screen
        if (pd_level) bad_nx = 1'b1;
        if (new_frame) begin
          if (cnt <= CNT_W'(1)) begin
            state_nx = S_TARGET;
            cnt_nx   = CNT_W'(TARGET_FRAMES);
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
      end
      S_TARGET: begin
        if (pd_level) seen_nx = 1'b1;
        if (new_frame) begin
          if (cnt <= CNT_W'(1)) begin
            state_nx = S_RESULT;
            hit_nx   = seen_nx & ~bad & ~dropped_nx;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
      end
      S_MCHECK: begin
        state_nx = S_RESULT;
        hit_nx   = in_span(duck_x, mouse_x, DUCK_W) && in_span(duck_y, mouse_y, DUCK_H);
      end
      S_RESULT: begin
        state_nx = S_COOLDOWN;
        cnt_nx   = CNT_W'(COOLDOWN_FRAMES);
      end
      S_COOLDOWN: begin
        if (cnt != '0) begin
          if (new_frame) cnt_nx = cnt - CNT_W'(1);
        end else if (!trig_level && !mouse_left) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (show_rise) shots_nx = AMMO;
  end

  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bad          <= 1'b0;
      seen         <= 1'b0;
      dropped      <= 1'b0;
      shots_left   <= AMMO;
      duck_show_q  <= 1'b0;
      mouse_q      <= 1'b0;
      flash_black  <= 1'b0;
      flash_target <= 1'b0;
      duck_hit     <= 1'b0;
      shot_miss    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      bad          <= bad_nx;
      seen         <= seen_nx;
      dropped      <= dropped_nx;
      shots_left   <= shots_nx;
      duck_show_q  <= duck_show;
      mouse_q      <= mouse_left;
      flash_black  <= (state_nx == S_BLACK);
      flash_target <= (state_nx == S_TARGET);
      duck_hit     <= (state_nx == S_RESULT) &  hit_nx;
      shot_miss    <= (state_nx == S_RESULT) & ~hit_nx;
      busy         <= (state_nx != S_IDLE);
    end
  end
endmodule

// File: tb/tb_shot_ctl.sv
// Directed-plus-random bench for shot_ctl; expectations come from a small shot-level
// model (ammo count, box arithmetic, frame lengths) kept here.
module tb_shot_ctl;
  import dh_pkg::*;

  localparam int FL  = 24;  // cycles per frame in this bench
  localparam int BF  = 1;
  localparam int TF  = 1;
  localparam int CF  = 10;
  localparam int SPD = 3;

  logic       clk = 1'b0, rst = 1'b1, new_frame = 1'b0;
  logic       gun_trigger = 1'b0, mouse_left = 1'b0, duck_show = 1'b0;
  logic       gun_photodetector;
  logic [9:0] mouse_x = '0, mouse_y = '0, duck_x = '0, duck_y = '0;
  logic       flash_black, flash_target, duck_hit, shot_miss, busy;
  logic [1:0] shots_left;

  int passed = 0, total = 0, fails = 0;
  int mdl_shots = SPD;
  int pd_mode = 0;  // 0 dark, 1 ideal gun (sees only the white box), 2 ambient light
  int fcnt = 0;

  shot_ctl dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .gun_trigger(gun_trigger),
    .gun_photodetector(gun_photodetector), .mouse_left(mouse_left),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .duck_x(duck_x), .duck_y(duck_y),
    .duck_show(duck_show), .flash_black(flash_black), .flash_target(flash_target),
    .duck_hit(duck_hit), .shot_miss(shot_miss), .shots_left(shots_left), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    fcnt      <= (fcnt == FL-1) ? 0 : fcnt + 1;
    new_frame <= (fcnt == FL-1);
  end

  assign gun_photodetector = (pd_mode == 1) ? flash_target : (pd_mode == 2);

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit box_hit(int dx, int dy, int mx, int my);
    return (mx >= dx) && (mx < dx + DUCK_W) && (my >= dy) && (my < dy + DUCK_H);
  endfunction

  function automatic int clamp(int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  task automatic reload();
    duck_show = 1'b0;
    cyc(3);
    duck_show = 1'b1;
    cyc(3);
    mdl_shots = SPD;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0, extra = 0;
    while (busy && g < (CF + 3) * FL) begin
      @(negedge clk);
      g++;
      extra += int'(duck_hit | shot_miss);
    end
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_extra"}, extra, 0);
  endtask

  // fire one shot and count what the outputs do up to its result pulse
  task automatic shot(input string tag, input bit gun, input bit hold, input bit drop,
                      input bit exp_hit);
    int nb = 0, nt = 0, nh = 0, nm = 0, nboth = 0, g = 0;
    bit done = 0;
    if (gun) gun_trigger = 1'b1;
    else     mouse_left  = 1'b1;
    while (!done && g < (BF + TF + 3) * FL) begin
      @(negedge clk);
      g++;
      if (!gun) mouse_left = 1'b0;
      if (gun && !hold && g == 4) gun_trigger = 1'b0;
      nb    += int'(flash_black);
      nt    += int'(flash_target);
      nh    += int'(duck_hit);
      nm    += int'(shot_miss);
      nboth += int'(duck_hit & shot_miss);
      if (drop && flash_black) duck_show = 1'b0;
      if (duck_hit || shot_miss) done = 1;
    end
    chk({tag, "_hit"}, nh, int'(exp_hit));
    chk({tag, "_miss"}, nm, int'(!exp_hit));
    chk({tag, "_both"}, nboth, 0);
    if (gun) begin
      chk({tag, "_black_cyc"}, nb, BF * FL);
      chk({tag, "_target_cyc"}, nt, TF * FL);
    end
    mdl_shots--;
    chk({tag, "_ammo"}, shots_left, mdl_shots);
    if (!hold) wait_idle(tag);
  endtask

  task automatic mouse_shot(input string tag, input int mx, input int my);
    if (mdl_shots == 0) reload();
    mouse_x = 10'(mx);
    mouse_y = 10'(my);
    cyc(1);
    shot(tag, 1'b0, 1'b0, 1'b0, box_hit(int'(duck_x), int'(duck_y), mx, my));
  endtask

  initial begin
    int dx, dy, busy_seen, pulses, g;
    bit tgt_seen;

    // reset state
    cyc(4);
    chk("rst_black", flash_black, 0);
    chk("rst_target", flash_target, 0);
    chk("rst_hit", duck_hit, 0);
    chk("rst_miss", shot_miss, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ammo", shots_left, SPD);
    rst = 1'b0;
    duck_show = 1'b1;
    cyc(4);

    // gun: ideal detector, then ambient light in the black frame
    duck_x = 10'($urandom_range(0, 900));
    duck_y = 10'($urandom_range(0, 900));
    pd_mode = 1;
    shot("gun_hit", 1'b1, 1'b0, 1'b0, 1'b1);
    pd_mode = 2;
    shot("gun_ambient", 1'b1, 1'b0, 1'b0, 1'b0);
    pd_mode = 0;

    // mouse box edges and right-edge no-wrap
    reload();
    dx = int'($urandom_range(0, 900));
    dy = int'($urandom_range(0, 900));
    duck_x = 10'(dx);
    duck_y = 10'(dy);
    mouse_shot("m_in_edge", dx + 63, dy);
    mouse_shot("m_out_edge", dx + 64, dy);
    duck_x = 10'd1000;
    duck_y = 10'd100;
    mouse_shot("m_nowrap_in", 1023, 100);
    mouse_shot("m_nowrap_out", 999, 100);

    // random clicks around random ducks
    for (int i = 0; i < 6; i++) begin
      dx = int'($urandom_range(0, 1023));
      dy = int'($urandom_range(0, 1023));
      duck_x = 10'(dx);
      duck_y = 10'(dy);
      mouse_shot("m_rand", clamp(dx - 8 + int'($urandom_range(0, 79))),
                           clamp(dy - 8 + int'($urandom_range(0, 79))));
    end

    // run out of ammo, then a trigger must be ignored
    reload();
    duck_x = 10'd400;
    duck_y = 10'd300;
    for (int i = 0; i < 3; i++)
      mouse_shot("m_empty", 399 - int'($urandom_range(0, 90)), 310);
    busy_seen = 0;
    pulses = 0;
    gun_trigger = 1'b1;
    for (int i = 0; i < 2 * FL; i++) begin
      @(negedge clk);
      if (i == 4) gun_trigger = 1'b0;
      busy_seen += int'(busy);
      pulses += int'(duck_hit | shot_miss);
    end
    chk("noammo_busy", busy_seen, 0);
    chk("noammo_pulse", pulses, 0);
    chk("noammo_ammo", shots_left, 0);
    reload();
    chk("reload_ammo", shots_left, SPD);

    // trigger held through cooldown; a click inside cooldown is dropped
    shot("held", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(FL);
    mouse_x = duck_x;
    mouse_y = duck_y;
    mouse_left = 1'b1;
    cyc(1);
    mouse_left = 1'b0;
    cyc((CF + 1) * FL);
    chk("held_busy", busy, 1);
    chk("held_ammo", shots_left, mdl_shots);
    gun_trigger = 1'b0;
    wait_idle("held_release");

    // reset in the middle of the target frame
    pd_mode = 1;
    tgt_seen = 0;
    g = 0;
    gun_trigger = 1'b1;
    while (!tgt_seen && g < 4 * FL) begin
      @(negedge clk);
      g++;
      if (g == 4) gun_trigger = 1'b0;
      tgt_seen = flash_target;
    end
    chk("rst_mid_seen", int'(tgt_seen), 1);
    cyc(FL / 2);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_target", flash_target, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 1'b0;
    pulses = 0;
    busy_seen = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      @(negedge clk);
      pulses += int'(duck_hit | shot_miss);
      busy_seen += int'(busy);
    end
    chk("rst_mid_pulse", pulses, 0);
    chk("rst_mid_idle", busy_seen, 0);
    chk("rst_mid_ammo", shots_left, SPD);
    mdl_shots = SPD;

    // duck leaves during the black frame: sequence completes, result is a miss
    shot("drop", 1'b1, 1'b0, 1'b1, 1'b0);
    pd_mode = 0;
    reload();
    chk("drop_reload", shots_left, SPD);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
